// File: rtl/r4_butterfly_stream.sv
// rtl/r4_butterfly_stream.sv - streaming radix-4 DFT butterfly, four bins emitted serially
// Accepts four complex samples per handshake and emits the four bins over a valid/ready port.
module r4_butterfly_stream #(
    parameter int W     = 8,
    parameter int SCALE = 0,
    localparam int OW   = (SCALE != 0) ? W : W + 2
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic          in_inv,
    input  logic [W-1:0]  xr0,
    input  logic [W-1:0]  xr1,
    input  logic [W-1:0]  xr2,
    input  logic [W-1:0]  xr3,
    input  logic [W-1:0]  xi0,
    input  logic [W-1:0]  xi1,
    input  logic [W-1:0]  xi2,
    input  logic [W-1:0]  xi3,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [OW-1:0] out_re,
    output logic [OW-1:0] out_im,
    output logic [1:0]    out_idx,
    output logic          out_last,
    output logic          busy
);

    localparam int EW = W + 2;

    typedef enum logic {IDLE, EMIT} state_t;

    state_t state, state_nxt;
    logic [1:0] idx;
    logic accept, fire;

    logic signed [EW-1:0] ar, ai, br, bi, cr, ci, dr, di;
    logic signed [EW-1:0] sr, si, tr, ti, ur, ui, vr, vi;
    logic signed [EW-1:0] fr [4];
    logic signed [EW-1:0] fi [4];
    logic [OW-1:0] nr [4];
    logic [OW-1:0] ni [4];
    logic [OW-1:0] rr [4];
    logic [OW-1:0] ri [4];

    function automatic logic signed [EW-1:0] sx(input logic [W-1:0] x);
        return {{2{x[W-1]}}, x};
    endfunction

    // Two guard bits make every sum exact: |X| <= 4 * 2^(W-1) = 2^(W+1).
    always_comb begin
        ar = sx(xr0); ai = sx(xi0);
        br = sx(xr1); bi = sx(xi1);
        cr = sx(xr2); ci = sx(xi2);
        dr = sx(xr3); di = sx(xi3);
        sr = ar + cr; si = ai + ci;
        tr = ar - cr; ti = ai - ci;
        ur = br + dr; ui = bi + di;
        vr = br - dr; vi = bi - di;
        fr[0] = sr + ur; fi[0] = si + ui;
        fr[2] = sr - ur; fi[2] = si - ui;
        if (!in_inv) begin
            fr[1] = tr + vi; fi[1] = ti - vr;
            fr[3] = tr - vi; fi[3] = ti + vr;
        end else begin
            fr[1] = tr - vi; fi[1] = ti + vr;
            fr[3] = tr + vi; fi[3] = ti - vr;
        end
    end

    generate
        if (SCALE != 0) begin : g_scale
            logic unused_lsbs;
            assign unused_lsbs = ^{fr[0][1:0], fr[1][1:0], fr[2][1:0], fr[3][1:0],
                                   fi[0][1:0], fi[1][1:0], fi[2][1:0], fi[3][1:0]};
            // Dropping the two LSBs of a two's-complement value is a floor divide by 4.
            always_comb begin
                for (int k = 0; k < 4; k++) begin
                    nr[k] = fr[k][EW-1:2];
                    ni[k] = fi[k][EW-1:2];
                end
            end
        end else begin : g_full
            always_comb begin
                for (int k = 0; k < 4; k++) begin
                    nr[k] = fr[k];
                    ni[k] = fi[k];
                end
            end
        end
    endgenerate

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) state <= IDLE;
        else     state <= state_nxt;
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            idx <= 2'd0;
            rr  <= '{default: '0};
            ri  <= '{default: '0};
        end else if (accept) begin
            idx <= 2'd0;
            rr  <= nr;
            ri  <= ni;
        end else if (fire) begin
            idx <= idx + 2'd1;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (in_valid) state_nxt = EMIT;
            EMIT: if (fire && idx == 2'd3 && !accept) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // in_ready looks through out_ready so a new set can follow the last beat with no bubble.
    always_comb begin
        in_ready  = (state == IDLE) || (state == EMIT && idx == 2'd3 && out_ready);
        out_valid = (state == EMIT);
        busy      = (state == EMIT);
        out_last  = (state == EMIT) && (idx == 2'd3);
        out_re    = (state == EMIT) ? rr[idx] : '0;
        out_im    = (state == EMIT) ? ri[idx] : '0;
    end

    assign out_idx = idx;
    assign accept  = in_valid & in_ready;
    assign fire    = out_valid & out_ready;

endmodule
